regfile_dump_reader: RTL
========================

Name: regfile_dump_reader

Overview:
- Bulk reader for the MIPS register file: on a start pulse it drives both register-file read ports to sweep every register, first the integer bank, then the float bank.
- Streams each register value out on a valid/ready word interface tagged with its address and bank.
- Used for debug and state dumps, and by the verification benches to check architectural state after a program.
- Sits beside the datapath and connects to the register file's readReg1/readReg2/float inputs when the core is halted.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 6, register address width, matching the register file read-port width.
- NUM_REGS, 32, registers per bank; must be even and at least 2.
- INCLUDE_FLOAT, 1, 1 = dump the integer bank then the float bank; 0 = integer bank only.

Ports:
- clk  in  1  clock (single clock domain).
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a dump; sampled only in IDLE.
- rd_addr1  out  ADDR_W  to register file readReg1.
- rd_addr2  out  ADDR_W  to register file readReg2.
- rd_float  out  1  to register file float select.
- rd_data1  in  DATA_W  from register file dataOut1 (combinational read).
- rd_data2  in  DATA_W  from register file dataOut2 (combinational read).
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts word.
- out_data  out  DATA_W  register value.
- out_addr  out  ADDR_W  register index of out_data.
- out_float  out  1  bank of out_data (1 = float).
- out_last  out  1  final word of the dump.
- busy  out  1  high from the start edge until DONE exits.
- done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (async, any state, including mid-dump): state=IDLE, idx=0, bank=0, buffers=0. All outputs 0, except rd_addr2=1. No partial stream resumes after reset.
- Read-port drive (all states): rd_addr1=idx, rd_addr2=idx+1, rd_float=bank, all from registers.
- Register-file reads are combinational. Data is captured at the clock edge ending the READ cycle.
- FSM states: IDLE, READ, SEND0, SEND1, DONE.
  - IDLE: start=1 -> READ, with idx=0, bank=0, busy=1.
  - READ: capture buf0<=rd_data1, buf1<=rd_data2 -> SEND0.
  - SEND0: out_valid=1, out_data=buf0, out_addr=idx. On out_valid&&out_ready -> SEND1.
  - SEND1: out_valid=1, out_data=buf1, out_addr=idx+1. On handshake:
    - If this pair is the last one (idx==NUM_REGS-2, and bank==1 or INCLUDE_FLOAT==0) -> DONE.
    - Else if idx==NUM_REGS-2: idx=0, bank=1 -> READ.
    - Else: idx+=2 -> READ.
  - DONE: done=1 for exactly one cycle, busy drops, -> IDLE.
- Output ordering: words are always emitted in ascending address within a bank, integer bank first. Total words = NUM_REGS*(1+INCLUDE_FLOAT).
- Throughput: with out_ready held high, 2 words per 3 cycles.
- Handshake rules:
  - out_data, out_addr, out_float and out_last hold stable while out_valid=1 and out_ready=0.
  - out_valid never drops before its handshake.
  - out_last=1 only on the final SEND1 word.
- out_float=bank throughout SEND0/SEND1.
- start asserted while busy (any state other than IDLE) is ignored, with no restart and no queuing.
- Register-file writes during a dump: a pair reflects the register values in its READ cycle. The dump is not an atomic snapshot.
- Register 0 of each bank is read and emitted like any other register, with no special casing.

Decomposition:
- Shared package: FSM state encoding constants (IDLE, READ, SEND0, SEND1, DONE) and the bank encodings INT_BANK=0, FLOAT_BANK=1. The register-file read-port address width lives in the same package.
- No sub-module. Index/bank counter and two-word buffer are inline; total roughly 150 lines.

Test Plan:
- Preload int r[i]=i+100 and float f[i]=i+200 through the register-file write port. Pulse start with out_ready=1 -> 64 words: addr 0..31 with out_float=0 and data 100..131, then addr 0..31 with out_float=1 and data 200..231. out_last only on float addr 31. done pulses 96 edges after the start edge.
- Same preload, toggle out_ready 1/0 every cycle -> identical 64-word sequence. Fields stay stable whenever valid && !ready. No dropped or duplicated words.
- Pulse start again at word 10 of an active dump -> stream continues unchanged to 64 words, with a single done pulse.
- Assert rst while word 20 is presented -> next cycle out_valid=0, busy=0, rd_addr1=0, rd_addr2=1. A new start then produces a full dump from int addr 0.
- INCLUDE_FLOAT=0, NUM_REGS=32 -> 32 words, out_float=0 throughout, out_last on addr 31, done 48 edges after start.
- During a dump, write int r[5]=0xDEADBEEF the cycle before the pair (4,5) READ cycle -> the addr 5 word carries 0xDEADBEEF.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants for the register-file dump reader: FSM encoding, bank codes
// and the register-file read-port address width.
package regfile_dump_reader_pkg;

  localparam int unsigned REGFILE_ADDR_W = 6;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_SEND0 = 3'd2;
  localparam logic [2:0] ST_SEND1 = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic INT_BANK   = 1'b0;
  localparam logic FLOAT_BANK = 1'b1;

endpackage

// File: rtl/regfile_dump_reader.sv
// Sweeps both register-file read ports over every register (integer bank, then
// optionally the float bank) and streams each value out on a valid/ready port.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = REGFILE_ADDR_W,
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned INCLUDE_FLOAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_float,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_float,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 2);
  localparam logic              INT_ONLY = (INCLUDE_FLOAT == 0);

  logic [2:0]        state, stateNext;
  logic [ADDR_W-1:0] idx, idxNext, idxPlus1;
  logic              bank, bankNext;
  logic [DATA_W-1:0] buf0, buf0Next, buf1, buf1Next;

  logic              handshake;
  logic              lastPair;
  logic              lastPairNext;
  logic              outValidNext;
  logic [DATA_W-1:0] outDataNext;
  logic [ADDR_W-1:0] outAddrNext;
  logic              outFloatNext;
  logic              outLastNext;

  assign handshake = out_valid && out_ready;
  assign lastPair  = (idx == LAST_IDX) && (bank == FLOAT_BANK || INT_ONLY);

  // Next-state, counter and buffer logic; output values derive from the next state
  always_comb begin
    stateNext    = state;
    idxNext      = idx;
    bankNext     = bank;
    buf0Next     = buf0;
    buf1Next     = buf1;
    outValidNext = 1'b0;
    outDataNext  = '0;
    outAddrNext  = '0;
    outFloatNext = 1'b0;
    outLastNext  = 1'b0;
    lastPairNext = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          stateNext = ST_READ;
          idxNext   = '0;
          bankNext  = INT_BANK;
        end
      end
      ST_READ: begin
        buf0Next  = rd_data1;
        buf1Next  = rd_data2;
        stateNext = ST_SEND0;
      end
      ST_SEND0: begin
        if (handshake) stateNext = ST_SEND1;
      end
      ST_SEND1: begin
        if (handshake) begin
          if (lastPair) begin
            stateNext = ST_DONE;
          end else if (idx == LAST_IDX) begin
            idxNext   = '0;
            bankNext  = FLOAT_BANK;
            stateNext = ST_READ;
          end else begin
            idxNext   = idx + ADDR_W'(2);
            stateNext = ST_READ;
          end
        end
      end
      ST_DONE: begin
        stateNext = ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase

    lastPairNext = (idxNext == LAST_IDX) && (bankNext == FLOAT_BANK || INT_ONLY);

    if (stateNext == ST_SEND0) begin
      outValidNext = 1'b1;
      outDataNext  = buf0Next;
      outAddrNext  = idxNext;
      outFloatNext = bankNext;
    end else if (stateNext == ST_SEND1) begin
      outValidNext = 1'b1;
      outDataNext  = buf1Next;
      outAddrNext  = idxNext + ADDR_W'(1);
      outFloatNext = bankNext;
      outLastNext  = lastPairNext;
    end
  end

  // State, counters, buffers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      idxPlus1  <= ADDR_W'(1);
      bank      <= INT_BANK;
      buf0      <= '0;
      buf1      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_float <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      idx       <= idxNext;
      idxPlus1  <= idxNext + ADDR_W'(1);
      bank      <= bankNext;
      buf0      <= buf0Next;
      buf1      <= buf1Next;
      out_valid <= outValidNext;
      out_data  <= outDataNext;
      out_addr  <= outAddrNext;
      out_float <= outFloatNext;
      out_last  <= outLastNext;
      busy      <= (stateNext != ST_IDLE);
      done      <= (stateNext == ST_DONE);
    end
  end

  assign rd_addr1 = idx;
  assign rd_addr2 = idxPlus1;
  assign rd_float = bank;

endmodule
